id_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage. It replaces the fixed load-use compare with per-register pending-write counters covering all long-latency producers: loads, DIV/MUL, and later CSR and AMO. It sits beside the decoder and regfile in ID. It takes decoded source and destination indices, retires pending writes from NWB write-back channels, and drives one stall signal to PC, ID and EX. It also accepts a kill input that cancels a squashed long-latency write.

---
 rtl/id_scoreboard_pkg.sv | 26 ++
 rtl/id_scoreboard_cnt_cell.sv | 38 +++
 rtl/id_scoreboard.sv | 101 ++++++++++
 tb/tb_id_scoreboard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg: shared register-file geometry and latency-class encoding for the ID scoreboard.
package id_scoreboard_pkg;
    localparam int SB_NREG  = 32;
    localparam int SB_IDX_W = $clog2(SB_NREG);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG_32 = 7'b0111011;

    typedef enum logic [1:0] {
        LAT_SHORT  = 2'd0,
        LAT_LOAD   = 2'd1,
        LAT_MULDIV = 2'd2,
        LAT_CSR    = 2'd3
    } lat_class_e;

    // fun_7[0] on OP_REG/OP_REG_32 selects the MUL/DIV unit
    function automatic lat_class_e lat_class(input logic [6:0] opcode, input logic fun7_0);
        return opcode == OP_LOAD ? LAT_LOAD :
               ((opcode == OP_REG || opcode == OP_REG_32) && fun7_0) ? LAT_MULDIV : LAT_SHORT;
    endfunction

    function automatic logic is_long(input lat_class_e c);
        return c != LAT_SHORT;
    endfunction
endpackage

// File: rtl/id_scoreboard_cnt_cell.sv
// sb_cnt_cell: one register's pending-write counter; saturates at both ends and latches an
// error when more writes retire than were outstanding.
module sb_cnt_cell #(
    parameter int CNT_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    localparam int SW = (CNT_W > DEC_W ? CNT_W : DEC_W) + 1;
    localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);

    logic [SW-1:0]    up;
    logic [SW-1:0]    diff;
    logic             under;
    logic [CNT_W-1:0] cnt_n;

    always_comb begin
        up    = SW'(cnt) + SW'(inc);
        under = SW'(dec) > up;
        diff  = up - SW'(dec);
        cnt_n = under ? '0 : (diff > MAX ? CNT_W'(MAX) : CNT_W'(diff));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_n;
            err <= err | under;
        end
    end
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register pending-write scoreboard for long-latency producers; stalls ID on
// RAW hazards and on counter exhaustion, retiring writes from NWB write-back channels and kills.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG      = SB_NREG,
    parameter int IDX_W     = SB_IDX_W,
    parameter int NWB       = 2,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1,
    parameter int PERF_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid_i,
    input  logic [IDX_W-1:0]   id_rs1_idx_i,
    input  logic               id_rs1_used_i,
    input  logic [IDX_W-1:0]   id_rs2_idx_i,
    input  logic               id_rs2_used_i,
    input  logic [IDX_W-1:0]   id_rd_idx_i,
    input  logic               id_wben_i,
    input  logic               id_long_i,
    input  logic [NWB-1:0]     wb_valid_i,
    input  logic [NWB*IDX_W-1:0] wb_rdid_i,
    input  logic               kill_valid_i,
    input  logic [IDX_W-1:0]   kill_rdid_i,
    output logic               stall_o,
    output logic               issue_o,
    output logic [NREG-1:0]    busy_o,
    output logic               pending_any_o,
    output logic               err_o,
    output logic [PERF_W-1:0]  stall_cycles_o
);
    localparam int DEC_W = $clog2(NWB + 2);
    localparam int SW    = (CNT_W > DEC_W ? CNT_W : DEC_W) + 1;
    localparam logic [SW-1:0] MAX_PEND = SW'((1 << CNT_W) - 1);

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0][DEC_W-1:0] dec;
    logic [NREG-1:0]            inc;
    logic [NREG-1:0]            err;
    logic [SW-1:0]              c1, d1, c2, d2, cr, dr;
    logic                       rs1_haz, rs2_haz, rd_haz;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int c = 0; c < NWB; c++)
                if (wb_valid_i[c] && wb_rdid_i[c*IDX_W +: IDX_W] == IDX_W'(r))
                    dec[r] = dec[r] + DEC_W'(1);
            if (kill_valid_i && kill_rdid_i == IDX_W'(r))
                dec[r] = dec[r] + DEC_W'(1);
        end
    end

    always_comb begin
        c1 = SW'(cnt[id_rs1_idx_i]);
        d1 = SW'(dec[id_rs1_idx_i]);
        c2 = SW'(cnt[id_rs2_idx_i]);
        d2 = SW'(dec[id_rs2_idx_i]);
        cr = SW'(cnt[id_rd_idx_i]);
        dr = SW'(dec[id_rd_idx_i]);
        rs1_haz = id_rs1_used_i && id_rs1_idx_i != '0 && c1 != '0 && !(WB_BYPASS != 0 && c1 == d1);
        rs2_haz = id_rs2_used_i && id_rs2_idx_i != '0 && c2 != '0 && !(WB_BYPASS != 0 && c2 == d2);
        // a kill/complete underflow makes cr-dr wrap, which can never equal MAX_PEND
        rd_haz  = id_long_i && id_wben_i && id_rd_idx_i != '0 && (cr - dr) == MAX_PEND;
        stall_o = id_valid_i && (rs1_haz || rs2_haz || rd_haz);
        issue_o = id_valid_i && !stall_o;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r]    = issue_o && id_long_i && id_wben_i && r != 0 && id_rd_idx_i == IDX_W'(r);
            busy_o[r] = cnt[r] != '0;
        end
    end

    assign cnt[0] = '0;
    assign err[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cell
        sb_cnt_cell #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .cnt   (cnt[r]),
            .err   (err[r])
        );
    end

    assign pending_any_o = |busy_o;
    assign err_o         = |err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles_o <= '0;
        else if (stall_o && stall_cycles_o != '1)
            stall_cycles_o <= stall_cycles_o + PERF_W'(1);
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenario tasks for id_scoreboard with hand-computed expectations.
module tb_id_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, rs1_used, rs2_used, wben, long_op, kill_valid;
    logic [4:0]  rs1, rs2, rd, kill_rdid;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rdid;
    logic        stall, issue, pending_any, err;
    logic [31:0] busy, stall_cycles;
    int          tests = 0;
    int          fails = 0;

    id_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_rs1_idx_i(rs1), .id_rs1_used_i(rs1_used),
        .id_rs2_idx_i(rs2), .id_rs2_used_i(rs2_used), .id_rd_idx_i(rd),
        .id_wben_i(wben), .id_long_i(long_op),
        .wb_valid_i(wb_valid), .wb_rdid_i(wb_rdid),
        .kill_valid_i(kill_valid), .kill_rdid_i(kill_rdid),
        .stall_o(stall), .issue_o(issue), .busy_o(busy),
        .pending_any_o(pending_any), .err_o(err), .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; rs1_used = 0; rs2_used = 0; wben = 0; long_op = 0; kill_valid = 0;
        rs1 = 0; rs2 = 0; rd = 0; kill_rdid = 0; wb_valid = 0; wb_rdid = 0;
    endtask

    task automatic long_issue(input logic [4:0] d);
        idle();
        id_valid = 1; wben = 1; long_op = 1; rd = d;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #12;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got %h want 0", busy); end
        tests++; if ({pending_any, err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {pending_any, err}); end
        tests++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d want 0", stall_cycles); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_load_use();
        @(negedge clk); long_issue(5); #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL lu_issue got %b want 1", issue); end
        @(negedge clk); idle(); id_valid = 1; rs1 = 5; rs1_used = 1; rd = 6; wben = 1; #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %b want 1", stall); end
        tests++; if (dut.cnt[5] !== 2'd1) begin fails++; $display("FAIL lu_cnt5 got %0d want 1", dut.cnt[5]); end
        @(negedge clk); wb_valid = 2'b01; wb_rdid = {5'd0, 5'd5}; #1;
        tests++; if ({stall, issue} !== 2'b01) begin fails++; $display("FAIL lu_bypass got %b want 01", {stall, issue}); end
        @(negedge clk); idle(); #1;
        tests++; if (busy[5] !== 1'b0 || pending_any !== 1'b0) begin fails++; $display("FAIL lu_release got %b%b want 00", busy[5], pending_any); end
        tests++; if (stall_cycles !== 32'd1) begin fails++; $display("FAIL lu_perf got %0d want 1", stall_cycles); end
    endtask

    task automatic test_rs2_hazard();
        @(negedge clk); long_issue(4);
        @(negedge clk); idle(); id_valid = 1; rs1 = 4; rs2 = 4; rs2_used = 1; #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rs2_stall got %b want 1", stall); end
        rs2_used = 0; #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL rs_unused got %b want 1", issue); end
        @(negedge clk); idle(); wb_valid = 2'b10; wb_rdid = {5'd4, 5'd0};
        @(negedge clk); idle(); #1;
        tests++; if (busy !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL rs2_drain got %h/%b want 0/0", busy, err); end
    endtask

    task automatic test_x0();
        @(negedge clk); long_issue(0); #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL x0_issue got %b want 1", issue); end
        @(negedge clk); idle(); wb_valid = 2'b11; wb_rdid = 10'd0; kill_valid = 1; kill_rdid = 0; #1;
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL x0_busy got %h want 0", busy); end
        @(negedge clk); idle(); #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL x0_err got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); long_issue(7); #1;
            tests++; if (issue !== 1'b1) begin fails++; $display("FAIL waw_issue%0d got %b want 1", i, issue); end
        end
        @(negedge clk); long_issue(7); #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL waw_full_stall got %b want 1", stall); end
        tests++; if (dut.cnt[7] !== 2'd3) begin fails++; $display("FAIL waw_cnt got %0d want 3", dut.cnt[7]); end
        @(negedge clk); wb_valid = 2'b11; wb_rdid = {5'd7, 5'd7}; #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL waw_dual_wb got %b want 1", issue); end
        @(negedge clk); idle(); #1;
        tests++; if (dut.cnt[7] !== 2'd2) begin fails++; $display("FAIL waw_net got %0d want 2", dut.cnt[7]); end
        wb_valid = 2'b11; wb_rdid = {5'd7, 5'd7};
        @(negedge clk); idle(); #1;
        tests++; if (busy[7] !== 1'b0) begin fails++; $display("FAIL waw_drain got %b want 0", busy[7]); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk); long_issue(9);
        @(negedge clk); long_issue(9); wb_valid = 2'b01; wb_rdid = {5'd0, 5'd9}; #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL sc_issue got %b want 1", issue); end
        @(negedge clk); idle(); #1;
        tests++; if (dut.cnt[9] !== 2'd1) begin fails++; $display("FAIL sc_cnt got %0d want 1", dut.cnt[9]); end
        wb_valid = 2'b10; wb_rdid = {5'd9, 5'd0};
        @(negedge clk); idle();
    endtask

    task automatic test_kill_err();
        @(negedge clk); long_issue(3);
        @(negedge clk); idle(); kill_valid = 1; kill_rdid = 3;
        @(negedge clk); idle(); #1;
        tests++; if (dut.cnt[3] !== 2'd0 || err !== 1'b0) begin fails++; $display("FAIL kill got cnt%0d err%b want 0/0", dut.cnt[3], err); end
        wb_valid = 2'b10; wb_rdid = {5'd12, 5'd0};
        @(negedge clk); idle(); #1;
        tests++; if (err !== 1'b1 || dut.cnt[12] !== 2'd0) begin fails++; $display("FAIL underflow got err%b cnt%0d want 1/0", err, dut.cnt[12]); end
        @(negedge clk); #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_stall_reset();
        rst_n = 0; #3;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
        @(negedge clk); rst_n = 1;
        @(negedge clk); long_issue(10);
        @(negedge clk); idle(); id_valid = 1; rs2 = 10; rs2_used = 1;
        repeat (5) @(negedge clk);
        #1;
        tests++; if (stall_cycles !== 32'd5 || stall !== 1'b1) begin fails++; $display("FAIL perf5 got %0d/%b want 5/1", stall_cycles, stall); end
        #1; rst_n = 0; #1;
        tests++; if (busy !== 32'h0 || stall_cycles !== 32'd0) begin fails++; $display("FAIL async_rst got %h/%0d want 0/0", busy, stall_cycles); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stall); end
        @(negedge clk); rst_n = 1; idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rs2_hazard();
        test_x0();
        test_back_to_back();
        test_same_cycle();
        test_kill_err();
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
